// File: rtl/vsdcaravel_pkg.sv
// Shared definitions for the housekeeping SPI block: register addresses,
// command codes, configuration reset values and the transaction state type.
package vsdcaravel_pkg;

    localparam logic [7:0] ADDR_MFGR_HI    = 8'h01;
    localparam logic [7:0] ADDR_MFGR_LO    = 8'h02;
    localparam logic [7:0] ADDR_PROD       = 8'h03;
    localparam logic [7:0] ADDR_USER0      = 8'h04;
    localparam logic [7:0] ADDR_USER1      = 8'h05;
    localparam logic [7:0] ADDR_USER2      = 8'h06;
    localparam logic [7:0] ADDR_USER3      = 8'h07;
    localparam logic [7:0] ADDR_PLL_ENA    = 8'h08;
    localparam logic [7:0] ADDR_PLL_BYPASS = 8'h09;
    localparam logic [7:0] ADDR_IRQ        = 8'h0A;
    localparam logic [7:0] ADDR_EXT_RESET  = 8'h0B;
    localparam logic [7:0] ADDR_TRIM0      = 8'h0D;
    localparam logic [7:0] ADDR_TRIM1      = 8'h0E;
    localparam logic [7:0] ADDR_TRIM2      = 8'h0F;
    localparam logic [7:0] ADDR_TRIM3      = 8'h10;
    localparam logic [7:0] ADDR_PLL_DIV    = 8'h11;
    localparam logic [7:0] ADDR_FB_DIV     = 8'h12;

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_RDWR  = 2'b11;

    localparam logic        RST_PLL_ENA     = 1'b0;
    localparam logic        RST_PLL_DCO_ENA = 1'b1;
    localparam logic        RST_PLL_BYPASS  = 1'b1;
    localparam logic        RST_IRQ         = 1'b0;
    localparam logic        RST_EXT_RESET   = 1'b0;
    localparam logic [25:0] RST_PLL_TRIM    = 26'h3FFEFFF;
    localparam logic [2:0]  RST_PLL_DIV     = 3'd2;
    localparam logic [2:0]  RST_PLL_SEL     = 3'd2;
    localparam logic [4:0]  RST_PLL_FB_DIV  = 5'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMMAND,
        ST_ADDRESS,
        ST_DATA
    } hk_state_e;

endpackage

// File: rtl/vsdcaravel_hkspi_slave.sv
// Mode-0 SPI slave sampled in the system clock domain; presents a simple
// addr/wdata/we/rdata register port to the enclosing register file.
module hkspi_slave
    import vsdcaravel_pkg::*;
(
    input  logic       clock,
    input  logic       resetb,
    input  logic       hk_sck,
    input  logic       hk_csb,
    input  logic       hk_sdi,
    output logic       hk_sdo,
    output logic       hk_sdo_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata
);

    logic [1:0] sck_sync_q, sck_sync_d;
    logic [1:0] csb_sync_q, csb_sync_d;
    logic [1:0] sdi_sync_q, sdi_sync_d;
    logic       sck_prev_q, sck_prev_d;
    logic       armed_q, armed_d;
    hk_state_e  state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_in_q, shift_in_d;
    logic [7:0] shift_out_q, shift_out_d;
    logic [7:0] addr_q, addr_d;
    logic       rd_mode_q, rd_mode_d;
    logic       wr_mode_q, wr_mode_d;

    logic       sck_s, csb_s, sdi_s;
    logic       sck_rise, sck_fall, byte_done;
    logic [7:0] shift_next;

    assign sck_s      = sck_sync_q[1];
    assign csb_s      = csb_sync_q[1];
    assign sdi_s      = sdi_sync_q[1];
    assign sck_rise   = sck_s & ~sck_prev_q;
    assign sck_fall   = ~sck_s & sck_prev_q;
    assign shift_next = {shift_in_q[6:0], sdi_s};
    assign byte_done  = sck_rise && (bit_cnt_q == 3'd7);

    assign reg_addr  = addr_q;
    assign reg_wdata = shift_next;
    assign hk_sdo_oe = (state_q == ST_DATA) && rd_mode_q;
    assign hk_sdo    = hk_sdo_oe & shift_out_q[7];

    always_comb begin
        sck_sync_d  = {sck_sync_q[0], hk_sck};
        csb_sync_d  = {csb_sync_q[0], hk_csb};
        sdi_sync_d  = {sdi_sync_q[0], hk_sdi};
        sck_prev_d  = sck_s;
        armed_d     = armed_q;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        addr_d      = addr_q;
        rd_mode_d   = rd_mode_q;
        wr_mode_d   = wr_mode_q;
        reg_we      = 1'b0;

        // A frame may only start after chip select has been seen high; this
        // covers both reset release mid-frame and the rest of a no-op frame.
        if (csb_s) begin
            armed_d   = 1'b1;
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
        end else if (state_q == ST_IDLE) begin
            if (armed_q) begin
                state_d   = ST_COMMAND;
                bit_cnt_d = 3'd0;
            end
        end else begin
            if (sck_rise) begin
                shift_in_d = shift_next;
                bit_cnt_d  = bit_cnt_q + 3'd1;
            end
            if (byte_done) begin
                case (state_q)
                    ST_COMMAND: begin
                        rd_mode_d = (shift_next[7:6] == CMD_READ) || (shift_next[7:6] == CMD_RDWR);
                        wr_mode_d = (shift_next[7:6] == CMD_WRITE) || (shift_next[7:6] == CMD_RDWR);
                        if (shift_next[7:6] == CMD_NOP) begin
                            state_d = ST_IDLE;
                            armed_d = 1'b0;
                        end else begin
                            state_d = ST_ADDRESS;
                        end
                    end
                    ST_ADDRESS: begin
                        addr_d  = shift_next;
                        state_d = ST_DATA;
                    end
                    default: begin
                        reg_we = wr_mode_q;
                        addr_d = addr_q + 8'd1;
                    end
                endcase
            end
            if (sck_fall && (state_q == ST_DATA) && rd_mode_q) begin
                shift_out_d = (bit_cnt_q == 3'd0) ? reg_rdata : {shift_out_q[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sck_sync_q  <= 2'b00;
            csb_sync_q  <= 2'b00;
            sdi_sync_q  <= 2'b00;
            sck_prev_q  <= 1'b0;
            armed_q     <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_in_q  <= 8'h00;
            shift_out_q <= 8'h00;
            addr_q      <= 8'h00;
            rd_mode_q   <= 1'b0;
            wr_mode_q   <= 1'b0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            csb_sync_q  <= csb_sync_d;
            sdi_sync_q  <= sdi_sync_d;
            sck_prev_q  <= sck_prev_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            addr_q      <= addr_d;
            rd_mode_q   <= rd_mode_d;
            wr_mode_q   <= wr_mode_d;
        end
    end

endmodule

// File: rtl/vsdcaravel.sv
// Housekeeping top level: holds the configuration register file behind the
// SPI slave and drives the PLL / reset / interrupt outputs from it.
module vsdcaravel
    import vsdcaravel_pkg::*;
#(
    parameter logic [11:0] MFGR_ID = 12'h456,
    parameter logic [7:0]  PROD_ID = 8'h11,
    parameter logic [31:0] USER_ID = 32'h0
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic        hk_sck,
    input  logic        hk_csb,
    input  logic        hk_sdi,
    output logic        hk_sdo,
    output logic        hk_sdo_oe,
    output logic        ext_reset,
    output logic        pll_ena,
    output logic        pll_dco_ena,
    output logic        pll_bypass,
    output logic        irq,
    output logic [25:0] pll_trim,
    output logic [2:0]  pll_div,
    output logic [2:0]  pll_sel,
    output logic [4:0]  pll_fb_div
);

    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_we;

    logic        pll_ena_q, pll_ena_d;
    logic        pll_dco_ena_q, pll_dco_ena_d;
    logic        pll_bypass_q, pll_bypass_d;
    logic        irq_q, irq_d;
    logic        ext_reset_q, ext_reset_d;
    logic [25:0] pll_trim_q, pll_trim_d;
    logic [2:0]  pll_div_q, pll_div_d;
    logic [2:0]  pll_sel_q, pll_sel_d;
    logic [4:0]  pll_fb_div_q, pll_fb_div_d;

    hkspi_slave u_hkspi (
        .clock     (clock),
        .resetb    (resetb),
        .hk_sck    (hk_sck),
        .hk_csb    (hk_csb),
        .hk_sdi    (hk_sdi),
        .hk_sdo    (hk_sdo),
        .hk_sdo_oe (hk_sdo_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_rdata (reg_rdata)
    );

    always_comb begin
        case (reg_addr)
            ADDR_MFGR_HI:    reg_rdata = {4'b0, MFGR_ID[11:8]};
            ADDR_MFGR_LO:    reg_rdata = MFGR_ID[7:0];
            ADDR_PROD:       reg_rdata = PROD_ID;
            ADDR_USER0:      reg_rdata = USER_ID[31:24];
            ADDR_USER1:      reg_rdata = USER_ID[23:16];
            ADDR_USER2:      reg_rdata = USER_ID[15:8];
            ADDR_USER3:      reg_rdata = USER_ID[7:0];
            ADDR_PLL_ENA:    reg_rdata = {6'b0, pll_dco_ena_q, pll_ena_q};
            ADDR_PLL_BYPASS: reg_rdata = {7'b0, pll_bypass_q};
            ADDR_IRQ:        reg_rdata = {7'b0, irq_q};
            ADDR_EXT_RESET:  reg_rdata = {7'b0, ext_reset_q};
            ADDR_TRIM0:      reg_rdata = pll_trim_q[7:0];
            ADDR_TRIM1:      reg_rdata = pll_trim_q[15:8];
            ADDR_TRIM2:      reg_rdata = pll_trim_q[23:16];
            ADDR_TRIM3:      reg_rdata = {6'b0, pll_trim_q[25:24]};
            ADDR_PLL_DIV:    reg_rdata = {2'b0, pll_sel_q, pll_div_q};
            ADDR_FB_DIV:     reg_rdata = {3'b0, pll_fb_div_q};
            default:         reg_rdata = 8'h00;
        endcase
    end

    // Read-only and unmapped addresses simply have no case arm here.
    always_comb begin
        pll_ena_d     = pll_ena_q;
        pll_dco_ena_d = pll_dco_ena_q;
        pll_bypass_d  = pll_bypass_q;
        irq_d         = irq_q;
        ext_reset_d   = ext_reset_q;
        pll_trim_d    = pll_trim_q;
        pll_div_d     = pll_div_q;
        pll_sel_d     = pll_sel_q;
        pll_fb_div_d  = pll_fb_div_q;
        if (reg_we) begin
            case (reg_addr)
                ADDR_PLL_ENA:    {pll_dco_ena_d, pll_ena_d} = reg_wdata[1:0];
                ADDR_PLL_BYPASS: pll_bypass_d = reg_wdata[0];
                ADDR_IRQ:        irq_d = reg_wdata[0];
                ADDR_EXT_RESET:  ext_reset_d = reg_wdata[0];
                ADDR_TRIM0:      pll_trim_d[7:0] = reg_wdata;
                ADDR_TRIM1:      pll_trim_d[15:8] = reg_wdata;
                ADDR_TRIM2:      pll_trim_d[23:16] = reg_wdata;
                ADDR_TRIM3:      pll_trim_d[25:24] = reg_wdata[1:0];
                ADDR_PLL_DIV:    {pll_sel_d, pll_div_d} = reg_wdata[5:0];
                ADDR_FB_DIV:     pll_fb_div_d = reg_wdata[4:0];
                default:         ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            pll_ena_q     <= RST_PLL_ENA;
            pll_dco_ena_q <= RST_PLL_DCO_ENA;
            pll_bypass_q  <= RST_PLL_BYPASS;
            irq_q         <= RST_IRQ;
            ext_reset_q   <= RST_EXT_RESET;
            pll_trim_q    <= RST_PLL_TRIM;
            pll_div_q     <= RST_PLL_DIV;
            pll_sel_q     <= RST_PLL_SEL;
            pll_fb_div_q  <= RST_PLL_FB_DIV;
        end else begin
            pll_ena_q     <= pll_ena_d;
            pll_dco_ena_q <= pll_dco_ena_d;
            pll_bypass_q  <= pll_bypass_d;
            irq_q         <= irq_d;
            ext_reset_q   <= ext_reset_d;
            pll_trim_q    <= pll_trim_d;
            pll_div_q     <= pll_div_d;
            pll_sel_q     <= pll_sel_d;
            pll_fb_div_q  <= pll_fb_div_d;
        end
    end

    assign pll_ena     = pll_ena_q;
    assign pll_dco_ena = pll_dco_ena_q;
    assign pll_bypass  = pll_bypass_q;
    assign irq         = irq_q;
    assign ext_reset   = ext_reset_q;
    assign pll_trim    = pll_trim_q;
    assign pll_div     = pll_div_q;
    assign pll_sel     = pll_sel_q;
    assign pll_fb_div  = pll_fb_div_q;

endmodule

// File: tb/tb_vsdcaravel.sv
// Bench for vsdcaravel: drives SPI frames bit by bit and checks read data and
// configuration outputs against a byte-array model of the register map.
module tb_vsdcaravel;

    logic        clock = 1'b0;
    logic        resetb = 1'b0;
    logic        hk_sck = 1'b0;
    logic        hk_csb = 1'b1;
    logic        hk_sdi = 1'b0;
    logic        hk_sdo, hk_sdo_oe, ext_reset, pll_ena, pll_dco_ena, pll_bypass, irq;
    logic [25:0] pll_trim;
    logic [2:0]  pll_div, pll_sel;
    logic [4:0]  pll_fb_div;

    vsdcaravel dut (
        .clock       (clock),
        .resetb      (resetb),
        .hk_sck      (hk_sck),
        .hk_csb      (hk_csb),
        .hk_sdi      (hk_sdi),
        .hk_sdo      (hk_sdo),
        .hk_sdo_oe   (hk_sdo_oe),
        .ext_reset   (ext_reset),
        .pll_ena     (pll_ena),
        .pll_dco_ena (pll_dco_ena),
        .pll_bypass  (pll_bypass),
        .irq         (irq),
        .pll_trim    (pll_trim),
        .pll_div     (pll_div),
        .pll_sel     (pll_sel),
        .pll_fb_div  (pll_fb_div)
    );

    always #10 clock = ~clock;

    int         total = 0;
    int         bad = 0;
    logic [7:0] model_mem [256];
    logic [7:0] model_mask [256];
    logic [7:0] wbuf [32];
    logic [7:0] rbuf [32];
    logic [7:0] expbuf [32];
    logic       oeAll;

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Register map as bytes: read value plus which bits a write may change.
    function automatic void modelReset();
        for (int i = 0; i < 256; i++) begin
            model_mem[i]  = 8'h00;
            model_mask[i] = 8'h00;
        end
        model_mem[8'h01] = 8'h04;
        model_mem[8'h02] = 8'h56;
        model_mem[8'h03] = 8'h11;
        model_mem[8'h08] = 8'h02; model_mask[8'h08] = 8'h03;
        model_mem[8'h09] = 8'h01; model_mask[8'h09] = 8'h01;
        model_mask[8'h0A] = 8'h01;
        model_mask[8'h0B] = 8'h01;
        model_mem[8'h0D] = 8'hFF; model_mask[8'h0D] = 8'hFF;
        model_mem[8'h0E] = 8'hEF; model_mask[8'h0E] = 8'hFF;
        model_mem[8'h0F] = 8'hFF; model_mask[8'h0F] = 8'hFF;
        model_mem[8'h10] = 8'h03; model_mask[8'h10] = 8'h03;
        model_mem[8'h11] = 8'h12; model_mask[8'h11] = 8'h3F;
        model_mem[8'h12] = 8'h04; model_mask[8'h12] = 8'h1F;
    endfunction

    function automatic void modelFrame(input logic [7:0] cmd, input logic [7:0] addr, input int n);
        logic [7:0] a;
        logic       isRead, isWrite;
        a       = addr;
        isRead  = (cmd[7:6] == 2'b01) || (cmd[7:6] == 2'b11);
        isWrite = (cmd[7:6] == 2'b10) || (cmd[7:6] == 2'b11);
        for (int i = 0; i < n; i++) begin
            expbuf[i] = isRead ? model_mem[a] : 8'h00;
            if (isWrite)
                model_mem[a] = (model_mem[a] & ~model_mask[a]) | (wbuf[i] & model_mask[a]);
            a = a + 8'd1;
        end
    endfunction

    task automatic spiBits(input logic [7:0] tx, input int nbits, output logic [7:0] rx, output logic oe);
        rx = 8'h00;
        oe = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            hk_sdi = tx[7-i];
            waitClocks(6);
            rx = {rx[6:0], hk_sdo};
            oe = oe & hk_sdo_oe;
            hk_sck = 1'b1;
            waitClocks(6);
            hk_sck = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] addr, input int n);
        logic [7:0] rx;
        logic       oe;
        hk_csb = 1'b0;
        waitClocks(4);
        spiBits(cmd, 8, rx, oe);
        spiBits(addr, 8, rx, oe);
        oeAll = 1'b1;
        for (int i = 0; i < n; i++) begin
            spiBits(wbuf[i], 8, rx, oe);
            rbuf[i] = rx;
            oeAll = oeAll & oe;
        end
        waitClocks(4);
        hk_csb = 1'b1;
        hk_sdi = 1'b0;
        waitClocks(8);
    endtask

    task automatic runFrame(input logic [7:0] cmd, input logic [7:0] addr, input int n, input string tag);
        modelFrame(cmd, addr, n);
        applyStimulus(cmd, addr, n);
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("%s_byte%0d", tag, i), 32'(rbuf[i]), 32'(expbuf[i]));
        checkOutput($sformatf("%s_oe", tag), 32'(oeAll),
                    32'((cmd[7:6] == 2'b01) || (cmd[7:6] == 2'b11)));
    endtask

    task automatic checkModelOutputs(input string tag);
        checkOutput({tag, "_pll_ena"},     32'(pll_ena),     32'(model_mem[8'h08][0]));
        checkOutput({tag, "_pll_dco_ena"}, 32'(pll_dco_ena), 32'(model_mem[8'h08][1]));
        checkOutput({tag, "_pll_bypass"},  32'(pll_bypass),  32'(model_mem[8'h09][0]));
        checkOutput({tag, "_irq"},         32'(irq),         32'(model_mem[8'h0A][0]));
        checkOutput({tag, "_ext_reset"},   32'(ext_reset),   32'(model_mem[8'h0B][0]));
        checkOutput({tag, "_pll_trim"},    32'(pll_trim),
                    32'({model_mem[8'h10][1:0], model_mem[8'h0F], model_mem[8'h0E], model_mem[8'h0D]}));
        checkOutput({tag, "_pll_div"},     32'(pll_div),     32'(model_mem[8'h11][2:0]));
        checkOutput({tag, "_pll_sel"},     32'(pll_sel),     32'(model_mem[8'h11][5:3]));
        checkOutput({tag, "_pll_fb_div"},  32'(pll_fb_div),  32'(model_mem[8'h12][4:0]));
    endtask

    initial begin
        logic [7:0] rx;
        logic       oe;
        logic [7:0] rcmd, raddr;
        int         rn;

        modelReset();
        waitClocks(5);
        checkOutput("reset_sdo", 32'(hk_sdo), 32'd0);
        checkOutput("reset_sdo_oe", 32'(hk_sdo_oe), 32'd0);
        checkModelOutputs("reset");
        resetb = 1'b1;
        waitClocks(6);

        runFrame(8'h40, 8'h03, 1, "rd03");
        checkOutput("rd03_prod_id", 32'(rbuf[0]), 32'h11);

        runFrame(8'h40, 8'h00, 19, "rdall");

        wbuf[0] = 8'h01;
        runFrame(8'h80, 8'h0B, 1, "wr0b_set");
        checkOutput("ext_reset_set", 32'(ext_reset), 32'd1);
        wbuf[0] = 8'h00;
        runFrame(8'h80, 8'h0B, 1, "wr0b_clr");
        checkOutput("ext_reset_clr", 32'(ext_reset), 32'd0);
        runFrame(8'h40, 8'h0B, 1, "rb0b");

        wbuf[0] = 8'hAA;
        runFrame(8'h80, 8'h02, 1, "wr02_ro");
        runFrame(8'h40, 8'h02, 1, "rb02");
        checkOutput("ro02_value", 32'(rbuf[0]), 32'h56);

        wbuf[0] = 8'h1F;
        runFrame(8'hC0, 8'h12, 1, "rw12");
        checkOutput("rw12_old", 32'(rbuf[0]), 32'h04);
        checkOutput("rw12_fb_div", 32'(pll_fb_div), 32'h1F);

        // Partial write byte to irq, aborted by chip select.
        hk_csb = 1'b0;
        waitClocks(4);
        spiBits(8'h80, 8, rx, oe);
        spiBits(8'h0A, 8, rx, oe);
        spiBits(8'hFF, 4, rx, oe);
        hk_csb = 1'b1;
        hk_sdi = 1'b0;
        waitClocks(8);
        checkOutput("partial_irq", 32'(irq), 32'd0);
        runFrame(8'h40, 8'h0A, 1, "partial_rb");

        wbuf[0] = 8'h01; wbuf[1] = 8'h01;
        runFrame(8'h2A, 8'h0A, 2, "noop");
        checkModelOutputs("noop");

        for (int k = 0; k < 8; k++) begin
            rcmd  = {2'($urandom_range(1, 3)), 6'($urandom)};
            raddr = 8'($urandom_range(0, 24));
            rn    = $urandom_range(1, 4);
            for (int i = 0; i < rn; i++)
                wbuf[i] = 8'($urandom);
            runFrame(rcmd, raddr, rn, $sformatf("rand%0d", k));
            checkModelOutputs($sformatf("rand%0d", k));
        end

        // Reset in the middle of a read stream.
        hk_csb = 1'b0;
        waitClocks(4);
        spiBits(8'h40, 8, rx, oe);
        spiBits(8'h0D, 8, rx, oe);
        spiBits(8'h00, 3, rx, oe);
        checkOutput("midread_oe_before", 32'(hk_sdo_oe), 32'd1);
        resetb = 1'b0;
        #1;
        checkOutput("midread_oe_reset", 32'(hk_sdo_oe), 32'd0);
        checkOutput("midread_sdo_reset", 32'(hk_sdo), 32'd0);
        modelReset();
        checkModelOutputs("midread");
        waitClocks(3);
        resetb = 1'b1;
        waitClocks(4);

        // Chip select never rose after reset, so this frame must be ignored.
        spiBits(8'h80, 8, rx, oe);
        spiBits(8'h0A, 8, rx, oe);
        spiBits(8'h01, 8, rx, oe);
        checkOutput("unarmed_irq", 32'(irq), 32'd0);
        hk_csb = 1'b1;
        hk_sdi = 1'b0;
        waitClocks(8);
        runFrame(8'h40, 8'h08, 11, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vsdcaravel.md
VSDCARAVEL -- requirements
Module: vsdcaravel

Interface
REQ-001 Parameters: MFGR_ID = 12'h456, manufacturer ID; PROD_ID = 8'h11, product ID; USER_ID = 32'h0, user project ID.
REQ-002 Ports, clock and reset first:
  - clock, input, 1, system clock, 40 MHz nominal.
  - resetb, input, 1, asynchronous active-low reset.
  - hk_sck, input, 1, housekeeping SPI clock, asynchronous to clock.
  - hk_csb, input, 1, SPI chip select, active low.
  - hk_sdi, input, 1, SPI data in.
  - hk_sdo, output, 1, SPI data out.
  - hk_sdo_oe, output, 1, SDO output enable.
  - ext_reset, output, 1, external core reset request.
  - pll_ena, output, 1, PLL enable.
  - pll_dco_ena, output, 1, PLL DCO enable.
  - pll_bypass, output, 1, PLL bypass.
  - irq, output, 1, SPI-triggered interrupt.
  - pll_trim, output, 26, PLL trim.
  - pll_div, output, 3, PLL output divider.
  - pll_sel, output, 3, PLL select.
  - pll_fb_div, output, 5, PLL feedback divider.
REQ-003 Design has one clock and an asynchronous active-low reset: clock and resetb; all state is clocked by clock.

Function
REQ-004 hk_sck, hk_csb and hk_sdi SHALL each pass through a 2-flop synchronizer. SCK rising and falling edges SHALL be detected in the clock domain.
REQ-005 SPI is mode 0, MSB first. SDI is sampled on SCK rise. SDO changes after SCK fall and SHALL be valid at most 3 clock cycles after the falling edge.
REQ-006 Transaction states: IDLE, COMMAND (8 bits), ADDRESS (8 bits), DATA (repeating 8-bit bytes).
  - hk_csb high SHALL return the block to IDLE from any state and abort any partial byte.
REQ-007 Command byte bits[7:6]:
  - 01 = read stream.
  - 10 = write stream.
  - 11 = read/write stream.
  - 00 = no-op; the rest of the frame is ignored.
  - Bits[5:0] are ignored.
REQ-008 After each data byte the address SHALL increment by 1 and wrap from 0xFF to 0x00.
REQ-009 Read: on the SCK fall after the last address bit (or the last bit of the previous data byte), the block loads reg[addr] and drives bit7 first. hk_sdo_oe = 1 only during read DATA; otherwise hk_sdo = 0.
REQ-010 Write: the byte is committed to reg[addr] on the SCK rise of its 8th bit. Read/write mode shifts out the old value while writing the new one.
REQ-011 Register map, read value, reset value:
  - 0x00 = 0x00, read-only.
  - 0x01 = {4'b0, MFGR_ID[11:8]}.
  - 0x02 = MFGR_ID[7:0].
  - 0x03 = PROD_ID.
  - 0x04..0x07 = USER_ID, MSB first.
  - 0x08 = {6'b0, pll_dco_ena, pll_ena}, reset 0x02.
  - 0x09 = {7'b0, pll_bypass}, reset 0x01.
  - 0x0A = {7'b0, irq}, reset 0x00.
  - 0x0B = {7'b0, ext_reset}, reset 0x00.
  - 0x0C = 0x00, read-only.
  - 0x0D..0x10 = pll_trim[7:0], [15:8], [23:16], {6'b0, [25:24]}, reset 0xFF, 0xEF, 0xFF, 0x03.
  - 0x11 = {2'b0, pll_sel, pll_div}, reset 0x12.
  - 0x12 = {3'b0, pll_fb_div}, reset 0x04.
  - All other addresses read 0x00 and ignore writes.
REQ-012 Writes to read-only addresses SHALL be discarded. Unused bits of writable registers read 0.
REQ-013 Every config output SHALL reflect its register field directly. The register stays unchanged by its own output, e.g. ext_reset does not reset the SPI block.

Reset
REQ-014 resetb low SHALL asynchronously clear synchronizers and state (IDLE) and load the REQ-011 reset values: hk_sdo = 0, hk_sdo_oe = 0, ext_reset = 0, irq = 0, pll_ena = 0, pll_dco_ena = 1, pll_bypass = 1, pll_trim = 26'h3FFEFFF, pll_div = 2, pll_sel = 2, pll_fb_div = 4.
REQ-015 resetb asserted mid-transaction SHALL abort it. After release, the next transaction needs hk_csb high then low.

Structure
REQ-016 A shared package SHALL hold the register address constants, command codes, reset values and the state enum.
REQ-017 One sub-module, hkspi_slave, SHALL contain the synchronizers, shifter and state machine and expose an addr/wdata/we/rdata register port. The top level holds the register file.

Verification
REQ-018 Each scenario, as stimulus -> required response:
  - After reset, read stream cmd 0x40 at addr 0x03 -> 0x11.
  - Read stream from addr 0x00 for 19 bytes -> 00 04 56 11 00 00 00 00 02 01 00 00 00 FF EF FF 03 12 04.
  - Write 0x01 to 0x0B -> ext_reset = 1. Write 0x00 -> ext_reset = 0, and 0x0B reads back 0x00.
  - Write 0xAA to 0x02 (read-only) -> 0x02 still reads 0x56. Read/write stream at 0x12 with data 0x1F -> returns 0x04, and pll_fb_div becomes 0x1F.
  - Raise hk_csb after 4 data bits of a write to 0x0A -> irq unchanged.
  - Assert resetb mid-read -> hk_sdo_oe = 0 and all registers at reset values.
